elevator_call_panel: RTL and testbench

//  Request side of the elevator floor_request interface. Takes raw asynchronous floor buttons and

---
 rtl/elevator_pkg.sv | 18 +
 rtl/call_button_debouncer.sv | 44 ++++
 rtl/elevator_call_panel.sv | 115 +++++++++++
 tb/tb_elevator_call_panel.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor encodings and door FSM state encoding.
// Used by the call panel and by the floor controller.
package elevator_pkg;

    localparam int FLOOR_W = 2;

    localparam logic [FLOOR_W-1:0] GROUND_FLOOR = 2'b00;
    localparam logic [FLOOR_W-1:0] FIRST_FLOOR  = 2'b01;
    localparam logic [FLOOR_W-1:0] SECOND_FLOOR = 2'b10;
    localparam logic [FLOOR_W-1:0] THIRD_FLOOR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        RETIRE = 2'b10
    } door_state_t;

endpackage

// File: rtl/call_button_debouncer.sv
// One floor button: 2-flop synchroniser, debounce counter and press-event
// edge detect. press_evt is a registered one-cycle pulse on an accepted
// 0->1 change of the debounced level.
module call_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic press_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw button, then count consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync1     <= button_in;
            sync2     <= sync1;
            press_evt <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level     <= sync2;
                cnt       <= '0;
                press_evt <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: debounced floor buttons feed a latched request
// register; a door FSM retires a request once the door has been held open
// at that floor. Optional build macro: CALL_PANEL_CANCEL_EN (a press on a
// pending floor other than the one being held cancels that request).
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS       = 4,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int DOOR_HOLD_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] button_in,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [NUM_FLOORS-1:0] floor_request,
    output logic                  request_pending,
    output logic                  serviced_pulse,
    output logic [FLOOR_W-1:0]    serviced_floor
);

    localparam int HOLD_W = $clog2(DOOR_HOLD_CYCLES + 1);

    logic [NUM_FLOORS-1:0] press_evt;
    logic [NUM_FLOORS-1:0] request_nxt;
    door_state_t           state;
    logic [FLOOR_W-1:0]    latched_floor;
    logic [HOLD_W-1:0]     hold_cnt;

    genvar g;
    generate
        for (g = 0; g < NUM_FLOORS; g++) begin : g_button
            call_button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk      (clk),
                .rst      (rst),
                .button_in(button_in[g]),
                .press_evt(press_evt[g])
            );
        end
    endgenerate

    // Next request vector: presses set idle floors; retire clears the latched floor and beats a same-floor press
    always_comb begin
        request_nxt = floor_request;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (press_evt[f]) begin
                if (!floor_request[f]) begin
                    request_nxt[f] = 1'b1;
                end
`ifdef CALL_PANEL_CANCEL_EN
                else if (!(state == HOLD && latched_floor == FLOOR_W'(f))) begin
                    request_nxt[f] = 1'b0;
                end
`endif
            end
        end
        if (state == RETIRE) begin
            request_nxt[latched_floor] = 1'b0;
        end
    end

    // Door FSM with the request register and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            latched_floor   <= GROUND_FLOOR;
            hold_cnt        <= '0;
            floor_request   <= '0;
            request_pending <= 1'b0;
            serviced_pulse  <= 1'b0;
            serviced_floor  <= GROUND_FLOOR;
        end else begin
            floor_request   <= request_nxt;
            request_pending <= |request_nxt;
            serviced_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    // A request cancelled on this same edge is not worth holding the door for
                    if (door_open && floor_request[current_floor] && request_nxt[current_floor]) begin
                        state         <= HOLD;
                        latched_floor <= current_floor;
                        hold_cnt      <= HOLD_W'(1);
                    end
                end
                HOLD: begin
                    if (door_open && current_floor == latched_floor) begin
                        if (press_evt[latched_floor]) begin
                            hold_cnt <= HOLD_W'(1);
                        end else if (hold_cnt == HOLD_W'(DOOR_HOLD_CYCLES - 1)) begin
                            state    <= RETIRE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end else begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                end
                RETIRE: begin
                    serviced_pulse <= 1'b1;
                    serviced_floor <= latched_floor;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel: directed scenarios followed by
// randomized button/door/floor activity, all checked against a behavioural
// model of the panel kept here.
module tb_elevator_call_panel;

    localparam int NF = 4;
    localparam int DB = 4;
    localparam int DH = 8;
`ifdef CALL_PANEL_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] button_in;
    logic [1:0]    current_floor;
    logic          door_open;
    logic [NF-1:0] floor_request;
    logic          request_pending;
    logic          serviced_pulse;
    logic [1:0]    serviced_floor;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [NF-1:0] raw_h1;
    logic [NF-1:0] raw_h2;
    logic [DB-1:0] win [NF];
    logic [NF-1:0] lvl;
    logic [NF-1:0] press_q;
    logic [NF-1:0] m_req;
    logic          m_pulse;
    logic [1:0]    m_sfloor;
    bit            holding;
    bit            retiring;
    int            hold_floor;
    int            open_count;

    elevator_call_panel #(
        .NUM_FLOORS      (NF),
        .DEBOUNCE_CYCLES (DB),
        .DOOR_HOLD_CYCLES(DH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .button_in      (button_in),
        .current_floor  (current_floor),
        .door_open      (door_open),
        .floor_request  (floor_request),
        .request_pending(request_pending),
        .serviced_pulse (serviced_pulse),
        .serviced_floor (serviced_floor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        raw_h1 = '0;
        raw_h2 = '0;
        for (int f = 0; f < NF; f++) win[f] = '0;
        lvl        = '0;
        press_q    = '0;
        m_req      = '0;
        m_pulse    = 1'b0;
        m_sfloor   = '0;
        holding    = 1'b0;
        retiring   = 1'b0;
        hold_floor = 0;
        open_count = 0;
    endtask

    // One clock edge of the model: a level change is accepted once the last DB
    // synchronised samples all disagree with it; the press takes effect next edge.
    task automatic model_edge();
        logic [NF-1:0] samp;
        logic [NF-1:0] fresh;
        logic [NF-1:0] nreq;
        int cf;
        samp   = raw_h2;
        raw_h2 = raw_h1;
        raw_h1 = button_in;
        fresh  = '0;
        for (int f = 0; f < NF; f++) begin
            win[f] = {win[f][DB-2:0], samp[f]};
            if (win[f] == {DB{~lvl[f]}}) begin
                lvl[f]   = ~lvl[f];
                fresh[f] = lvl[f];
            end
        end
        nreq = m_req;
        for (int f = 0; f < NF; f++) begin
            if (press_q[f]) begin
                if (!m_req[f]) nreq[f] = 1'b1;
                else if (CANCEL && !(holding && hold_floor == f)) nreq[f] = 1'b0;
            end
        end
        cf      = int'(current_floor);
        m_pulse = 1'b0;
        if (retiring) begin
            nreq[hold_floor] = 1'b0;
            m_pulse  = 1'b1;
            m_sfloor = 2'(hold_floor);
            retiring = 1'b0;
        end else if (holding) begin
            if (door_open && cf == hold_floor) begin
                if (press_q[hold_floor]) open_count = 1;
                else open_count++;
                if (open_count == DH) begin
                    holding  = 1'b0;
                    retiring = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
        end else if (door_open && m_req[cf] && nreq[cf]) begin
            holding    = 1'b1;
            hold_floor = cf;
            open_count = 1;
        end
        m_req   = nreq;
        press_q = fresh;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("floor_request", 8'(floor_request), 8'(m_req));
        chk("request_pending", 8'(request_pending), 8'(|m_req));
        chk("serviced_pulse", 8'(serviced_pulse), 8'(m_pulse));
        chk("serviced_floor", 8'(serviced_floor), 8'(m_sfloor));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 8'(floor_request), 8'h00);
        chk({tag, "_pending"}, 8'(request_pending), 8'h00);
        chk({tag, "_pulse"}, 8'(serviced_pulse), 8'h00);
        chk({tag, "_sfloor"}, 8'(serviced_floor), 8'h00);
    endtask

    initial begin
        int found;
        rst           = 1'b0;
        button_in     = '0;
        current_floor = '0;
        door_open     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        // Clean press on floor 2: request appears exactly 7 edges after the rise
        button_in = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 6) chk("latency_early", 8'(floor_request), 8'h00);
            if (i == 7) begin
                chk("latency_set", 8'(floor_request), 8'h04);
                chk("latency_pending", 8'(request_pending), 8'h01);
            end
        end
        button_in = '0;
        repeat (8) tick();

        // 3-cycle glitch on floor 1 is rejected
        button_in = 4'b0010;
        repeat (3) tick();
        button_in = '0;
        repeat (10) tick();
        chk("glitch_reject", 8'(floor_request), 8'h04);

        // Real press on floor 1
        button_in = 4'b0010;
        repeat (8) tick();
        button_in = '0;
        repeat (8) tick();
        chk("two_pending", 8'(floor_request), 8'h06);

        // Press on already pending floor 2 with no door activity
        button_in = 4'b0100;
        repeat (8) tick();
        button_in = '0;
        repeat (8) tick();
`ifdef CALL_PANEL_CANCEL_EN
        chk("cancel_press", 8'(floor_request), 8'h02);
`else
        chk("repeat_press", 8'(floor_request), 8'h06);
`endif

        // Service floor 1: door open 8 edges, pulse seen after the 9th
        current_floor = 2'd1;
        door_open     = 1'b1;
        found         = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (found < 0 && serviced_pulse === 1'b1) found = i;
        end
        door_open = 1'b0;
        chk("service1_edge", 8'(found), 8'd9);
        chk("service1_floor", 8'(serviced_floor), 8'd1);
`ifdef CALL_PANEL_CANCEL_EN
        chk("service1_req", 8'(floor_request), 8'h00);
`else
        chk("service1_req", 8'(floor_request), 8'h04);
`endif

        // Floor 3: door drops after 5 edges, request survives; reopen retires it
        button_in = 4'b1000;
        repeat (8) tick();
        button_in = '0;
        repeat (8) tick();
        current_floor = 2'd3;
        door_open     = 1'b1;
        found         = -1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (found < 0 && serviced_pulse === 1'b1) found = i;
        end
        door_open = 1'b0;
        for (int i = 6; i <= 8; i++) begin
            tick();
            if (found < 0 && serviced_pulse === 1'b1) found = i;
        end
        chk("door_drop_no_pulse", 8'(found), 8'hFF);
        chk("door_drop_keeps", 8'(floor_request[3]), 8'h01);
        door_open = 1'b1;
        found     = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (found < 0 && serviced_pulse === 1'b1) found = i;
        end
        door_open = 1'b0;
        chk("service3_edge", 8'(found), 8'd9);
        chk("service3_floor", 8'(serviced_floor), 8'd3);
        chk("service3_bit", 8'(floor_request[3]), 8'h00);

        // Floor 0: press during hold extends the door time
        button_in = 4'b0001;
        repeat (8) tick();
        button_in = '0;
        repeat (8) tick();
        current_floor = 2'd0;
        door_open     = 1'b1;
        button_in     = 4'b0001;
        found         = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (found < 0 && serviced_pulse === 1'b1) found = i;
        end
        button_in = '0;
        door_open = 1'b0;
        chk("extend_edge", 8'(found), 8'd15);
        chk("extend_floor", 8'(serviced_floor), 8'd0);
        repeat (8) tick();

        // Two floors pressed together, then reset asserted mid-hold
        button_in = 4'b0011;
        repeat (8) tick();
        chk("multi_press", 8'(floor_request[1:0]), 8'h03);
        button_in = '0;
        repeat (8) tick();
        current_floor = 2'd0;
        door_open     = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b0;
        #1 chk_all_zero("async_reset");
        model_reset();
        door_open = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Randomized activity
        repeat (600) begin
            for (int f = 0; f < NF; f++) begin
                if ($urandom_range(5) == 0) button_in[f] = ~button_in[f];
            end
            if ($urandom_range(9) == 0) current_floor = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) door_open = ~door_open;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
